// File: rtl/zion_pipe_stage_ctrl_pkg.sv
// Shared types and helpers for the elastic pipeline stage controller.
package zion_pipe_stage_ctrl_pkg;

  localparam int PERF_CNT_W = 32;

  typedef logic [PERF_CNT_W-1:0] perf_cnt_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic perf_cnt_t sat_inc(input perf_cnt_t v, input logic inc);
    return (inc && (v != '1)) ? v + perf_cnt_t'(1) : v;
  endfunction

endpackage

// File: rtl/zion_pipe_stage_ctrl_if.sv
// Handshake, stage-control and (ZION_PIPE_STAGE_CTRL_PERF_EN) perf-counter bundle
// between the stage controller (slave) and its surroundings (master).
interface zion_pipe_stage_ctrl_if
  import zion_pipe_stage_ctrl_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int CNT_W  = $clog2(STAGES + 1)
);

  logic              iValid;
  logic              oReady;
  logic              oValid;
  logic              iReady;
  logic              iFlush;
  logic [STAGES-1:0] oEn;
  logic [STAGES-1:0] oClr;
  logic [CNT_W-1:0]  oCnt;

`ifdef ZION_PIPE_STAGE_CTRL_PERF_EN
  perf_cnt_t oStallCnt;
  perf_cnt_t oFlushCnt;

  modport master (
    output iValid, iReady, iFlush,
    input  oReady, oValid, oEn, oClr, oCnt, oStallCnt, oFlushCnt
  );

  modport slave (
    input  iValid, iReady, iFlush,
    output oReady, oValid, oEn, oClr, oCnt, oStallCnt, oFlushCnt
  );
`else
  modport master (
    output iValid, iReady, iFlush,
    input  oReady, oValid, oEn, oClr, oCnt
  );

  modport slave (
    input  iValid, iReady, iFlush,
    output oReady, oValid, oEn, oClr, oCnt
  );
`endif

endinterface

// File: rtl/zion_pipe_stage_ctrl_cell.sv
// One pipeline stage: its valid bit, its link in the ready chain and its load enable.
module zion_pipe_stage_ctrl_cell (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  input  logic rdy_nxt_i,
  input  logic flush_i,
  output logic vld_o,
  output logic rdy_o,
  output logic en_o
);

  logic vld_q, vld_d;

  // An empty stage is always ready, which is what collapses bubbles.
  assign rdy_o = !vld_q | rdy_nxt_i;
  assign en_o  = rdy_o & in_i & !flush_i & rst;
  assign vld_o = vld_q;

  always_comb begin
    vld_d = vld_q;
    if (flush_i)    vld_d = 1'b0;
    else if (rdy_o) vld_d = in_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) vld_q <= 1'b0;
    else      vld_q <= vld_d;
  end

endmodule

// File: rtl/zion_pipe_stage_ctrl.sv
// Elastic pipeline controller: per-stage valid bits, enables/clears, flush.
// Optional stall/flush counters under ZION_PIPE_STAGE_CTRL_PERF_EN.
module zion_pipe_stage_ctrl
  import zion_pipe_stage_ctrl_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  zion_pipe_stage_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(STAGES + 1);

  if ((STAGES < 1) || (STAGES > 16)) begin : g_chk_stages
    $error("zion_pipe_stage_ctrl: STAGES=%0d outside 1..16", STAGES);
  end
  if (($bits(bus.oEn) != STAGES) || ($bits(bus.oClr) != STAGES)) begin : g_chk_width
    $error("zion_pipe_stage_ctrl: oEn/oClr width differs from STAGES=%0d", STAGES);
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] stage_in;
  logic [STAGES-1:0] en;
  logic [STAGES:0]   rdy;
  logic [CNT_W-1:0]  cnt;

  assign rdy[STAGES] = bus.iReady;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in[k] = bus.iValid;
    end else begin : g_body
      assign stage_in[k] = vld[k-1];
    end

    zion_pipe_stage_ctrl_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .in_i      (stage_in[k]),
      .rdy_nxt_i (rdy[k+1]),
      .flush_i   (bus.iFlush),
      .vld_o     (vld[k]),
      .rdy_o     (rdy[k]),
      .en_o      (en[k])
    );
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < STAGES; k++) cnt = cnt + CNT_W'(vld[k]);
  end

  assign bus.oEn    = en;
  assign bus.oClr   = {STAGES{!rst | bus.iFlush}};
  assign bus.oReady = rdy[0] & !bus.iFlush & rst;
  assign bus.oValid = vld[STAGES-1] & !bus.iFlush & rst;
  assign bus.oCnt   = cnt;

`ifdef ZION_PIPE_STAGE_CTRL_PERF_EN
  perf_cnt_t stall_cnt_q, stall_cnt_d;
  perf_cnt_t flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, vld[STAGES-1] & !bus.iReady & !bus.iFlush);
    flush_cnt_d = sat_inc(flush_cnt_q, bus.iFlush);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.oStallCnt = stall_cnt_q;
  assign bus.oFlushCnt = flush_cnt_q;
`endif

endmodule
